// File: rtl/hazard_sequencer.sv
`default_nettype none
// hazard_sequencer: load-use stalls, taken-branch flushes and multdiv sequencing for the 5-stage core.
// rev 1.0
module hazard_sequencer #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_out_ir,
  input  logic [31:0] dx_out_ir,
  input  logic        branch_taken,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        xm_bubble,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_result_sel,
  output logic        md_over,
  output logic        md_busy
);

  localparam logic [4:0] c_OP_RTYPE = 5'b00000;
  localparam logic [4:0] c_OP_LW    = 5'b01000;
  localparam logic [4:0] c_OP_SW    = 5'b00111;
  localparam logic [4:0] c_OP_BNE   = 5'b00010;
  localparam logic [4:0] c_OP_BLT   = 5'b00110;
  localparam logic [4:0] c_OP_JR    = 5'b00100;
  localparam logic [4:0] c_OP_BEX   = 5'b10110;
  localparam logic [4:0] c_ALU_MUL  = 5'b00110;
  localparam logic [4:0] c_ALU_DIV  = 5'b00111;
  localparam logic [4:0] c_REG_R30  = 5'd30;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MD_START = 2'd1,
    ST_MD_WAIT  = 2'd2,
    ST_MD_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_over;

  logic [4:0] w_fd_op, w_dx_op, w_dx_rd, w_fd_rs1, w_fd_rs2;
  logic       w_fd_has_rs2, w_fd_sw, w_dx_mul, w_dx_div, w_dx_md, w_dx_lw;
  logic       w_load_use, w_cnt_last;
  logic       w_unused_bits;

  assign w_fd_op  = fd_out_ir[31:27];
  assign w_dx_op  = dx_out_ir[31:27];
  assign w_dx_rd  = dx_out_ir[26:22];
  assign w_fd_rs1 = fd_out_ir[21:17];
  assign w_fd_sw  = (w_fd_op == c_OP_SW);
  assign w_dx_lw  = (w_dx_op == c_OP_LW);
  assign w_dx_mul = (w_dx_op == c_OP_RTYPE) && (dx_out_ir[6:2] == c_ALU_MUL);
  assign w_dx_div = (w_dx_op == c_OP_RTYPE) && (dx_out_ir[6:2] == c_ALU_DIV);
  assign w_dx_md  = w_dx_mul | w_dx_div;
  assign w_cnt_last = (r_cnt == c_CNT_LAST);
  assign w_unused_bits = ^{fd_out_ir[11:0], dx_out_ir[21:7], dx_out_ir[1:0]};

  // Branches, jr and sw carry their second source register in the rd field.
  always_comb begin
    w_fd_rs2     = 5'd0;
    w_fd_has_rs2 = 1'b0;
    if (w_fd_op == c_OP_RTYPE) begin
      w_fd_rs2     = fd_out_ir[16:12];
      w_fd_has_rs2 = 1'b1;
    end else if (w_fd_op == c_OP_BEX) begin
      w_fd_rs2     = c_REG_R30;
      w_fd_has_rs2 = 1'b1;
    end else if ((w_fd_op == c_OP_BNE) || (w_fd_op == c_OP_BLT) ||
                 (w_fd_op == c_OP_JR)  || w_fd_sw) begin
      w_fd_rs2     = fd_out_ir[26:22];
      w_fd_has_rs2 = 1'b1;
    end
  end

  // Store data of a sw is forwarded MW->XM, so only its base register can stall.
  assign w_load_use = w_dx_lw && (w_dx_rd != 5'd0) &&
                      ((w_dx_rd == w_fd_rs1) ||
                       (w_fd_has_rs2 && !w_fd_sw && (w_dx_rd == w_fd_rs2)));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE:     if (!branch_taken && w_dx_md) r_is_div <= w_dx_div;
        ST_MD_START: r_cnt <= '0;
        ST_MD_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (md_result_rdy)   r_over <= md_exception;
          else if (w_cnt_last) r_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    pc_en         = 1'b1;
    fd_en         = 1'b1;
    dx_en         = 1'b1;
    fd_flush      = 1'b0;
    dx_bubble     = 1'b0;
    xm_bubble     = 1'b0;
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    md_result_sel = 1'b0;
    md_over       = 1'b0;
    md_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (branch_taken) begin
          fd_flush  = 1'b1;
          dx_bubble = 1'b1;
        end else if (w_dx_md) begin
          w_state_nxt = ST_MD_START;
        end else if (w_load_use) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_bubble = 1'b1;
        end
      end
      ST_MD_START, ST_MD_WAIT: begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        dx_en     = 1'b0;
        xm_bubble = 1'b1;
        md_busy   = 1'b1;
        if (r_state == ST_MD_START) begin
          ctrl_mult   = !r_is_div;
          ctrl_div    = r_is_div;
          w_state_nxt = ST_MD_WAIT;
        end else if (md_result_rdy || w_cnt_last) begin
          w_state_nxt = ST_MD_DONE;
        end
      end
      ST_MD_DONE: begin
        md_result_sel = 1'b1;
        md_over       = r_over;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!reset_n) begin
      pc_en         = 1'b0;
      fd_en         = 1'b0;
      dx_en         = 1'b0;
      fd_flush      = 1'b1;
      dx_bubble     = 1'b1;
      xm_bubble     = 1'b1;
      ctrl_mult     = 1'b0;
      ctrl_div      = 1'b0;
      md_result_sel = 1'b0;
      md_over       = 1'b0;
      md_busy       = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control block for the 5-stage core.
- Generates per-stage latch enables and bubble/flush controls from the FD/DX instruction registers.
- Sequences the multicycle multdiv unit: start pulse, pipeline freeze while busy, result capture, timeout.
- Works alongside the X-stage operand bypass; it covers the hazards bypassing cannot resolve (load-use, multdiv latency, taken branches).

Parameters:
- MD_TIMEOUT, 40, MD_WAIT cycles before forced completion.
- CNT_W, 6, width of the multdiv cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  core clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- fd_out_ir  in  32  instruction in FD latch
- dx_out_ir  in  32  instruction in DX latch
- branch_taken  in  1  X-stage resolved taken branch/jump (bne, blt, jr, bex, j, jal)
- md_result_rdy  in  1  multdiv result valid, one-cycle pulse
- md_exception  in  1  multdiv exception, qualified by md_result_rdy
- pc_en  out  1  PC register write enable
- fd_en  out  1  FD latch write enable
- dx_en  out  1  DX latch write enable
- fd_flush  out  1  load nop into FD
- dx_bubble  out  1  load nop into DX
- xm_bubble  out  1  load nop into XM
- ctrl_mult  out  1  multdiv start, multiply
- ctrl_div  out  1  multdiv start, divide
- md_result_sel  out  1  XM captures the multdiv result instead of the ALU result
- md_over  out  1  overflow flag into XM; XM/MW destination becomes r30
- md_busy  out  1  high in MD_START and MD_WAIT

Behaviour:
- Decode:
  - opcode = ir[31:27]; R-type = 00000 with ALU op ir[6:2].
  - mul = R-type with op 00110; div = R-type with op 00111; lw = 01000; sw = 00111.
  - branches bne = 00010, blt = 00110; jr = 00100; bex = 10110.
- Load-use:
  - DX is lw with rd = dx[26:22] != 0.
  - FD rs1 = fd[21:17].
  - FD rs2 = fd[16:12] for R-type, r30 for bex, fd[26:22] for bne/blt/jr/sw.
  - Stall when rd == rs1, or rd == rs2 and FD is not sw. A sw store-data dependency is resolved by the MW-to-XM data bypass instead.
  - Stall response: pc_en=0, fd_en=0, dx_bubble=1 for exactly one cycle.
- FSM states: IDLE, MD_START, MD_WAIT, MD_DONE.
- IDLE:
  - DX holds mul/div and branch_taken=0 → MD_START.
  - Default outputs: all enables 1, other outputs 0.
- MD_START (1 cycle):
  - ctrl_mult or ctrl_div = 1 (never both).
  - pc_en=fd_en=dx_en=0, xm_bubble=1; counter cleared to 0.
  - → MD_WAIT.
- MD_WAIT:
  - Freeze as in MD_START; counter increments each cycle.
  - md_result_rdy → MD_DONE.
  - Counter == MD_TIMEOUT-1 → MD_DONE with forced overflow.
- MD_DONE (1 cycle):
  - All enables 1, md_result_sel=1.
  - md_over = md_exception, or 1 if entered by timeout.
  - → IDLE. The mul/div leaves DX this cycle, so it is never restarted.
- Branch flush:
  - branch_taken in IDLE gives fd_flush=1, dx_bubble=1, pc_en=1.
  - Overrides a load-use stall in the same cycle.
  - branch_taken is ignored outside IDLE; it cannot coincide with mul/div in X.
- Priority in IDLE, highest first: branch_taken, mul/div start, load-use stall.
- Registered vs combinational:
  - All outputs are registered state decodes except the load-use and branch controls, which are combinational from inputs in IDLE.
- Reset (reset_n=0 at clock edge):
  - State → IDLE, counter → 0.
  - While reset is held: pc_en=fd_en=dx_en=0, fd_flush=dx_bubble=xm_bubble=1, all other outputs 0.
  - Reset during MD_WAIT aborts the operation; no MD_DONE is produced.
- md_result_rdy while not in MD_WAIT is ignored.

Test Plan:
- lw r5 in DX, FD add r6,r5,r1 → one cycle pc_en=0, fd_en=0, dx_bubble=1, then all enables 1.
- lw r5 in DX, FD sw r5,0(r2) → no stall. lw r0 in DX, FD reads r0 → no stall.
- mul in DX, md_result_rdy at 5th MD_WAIT cycle:
  - ctrl_mult one pulse; md_busy 6 cycles; xm_bubble 6 cycles.
  - Then md_result_sel=1 for one cycle and back to IDLE.
- div with md_result_rdy=1 and md_exception=1 → MD_DONE with md_over=1. Same op with no rdy → MD_DONE after MD_TIMEOUT=40 wait cycles with md_over=1.
- branch_taken=1 while DX is lw and FD has a load-use conflict → fd_flush=1, dx_bubble=1, pc_en=1; no stall cycle.
- reset_n=0 mid MD_WAIT → next cycle state IDLE, md_busy=0. A later md_result_rdy pulse produces no md_result_sel.
